spi_reg_slave: RTL and testbench
================================

# spi_reg_slave

Serial register-access front end for the chip's control register map. It receives SPI mode-0 frames on synchronously oversampled pins and decodes each frame into an 11-bit register address plus 8-bit write data. For every completed write byte it issues a single-cycle transfer-complete strobe (`xfc`), which feeds the trigger generator and the register file directly downstream. For reads it returns `rdata` on `miso`.

## Interface
Parameters:
- `ADDR_W`, default 11: register address width.
- `DATA_W`, default 8: data byte width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  master clock. `sck` frequency must be ≤ clk/8.
- `rst`  in  1  asynchronous active-low reset.
- `sck`  in  1  SPI clock from pad, asynchronous.
- `cs_n`  in  1  SPI chip select from pad, active low, asynchronous.
- `mosi`  in  1  SPI serial data in, asynchronous.
- `miso`  out  1  SPI serial data out.
- `miso_oe`  out  1  pad output enable; high while `cs_n` is low.
- `address`  out  11  register address; held between updates.
- `wdata`  out  8  write data; held between updates.
- `xfc`  out  1  one-cycle pulse when a write byte is complete.
- `rd`  out  1  one-cycle pulse when `rdata` is captured for a read byte.
- `rdata`  in  8  read data from the register file for the current `address`.

## Operation
- Synchronisers:
  - `sck`, `cs_n` and `mosi` each pass through 2 flops.
  - A third flop on `sck` and on `cs_n` provides edge detection.
- SPI mode 0:
  - Sample `mosi` on `sck` rise, MSB first.
  - Shift `miso` on `sck` fall.
- Frame layout, MSB first:
  - bit 23: R/W (1 = write).
  - bits 22:19: reserved, ignored.
  - bits 18:8: address.
  - bits 7:0: data byte.
- State machine: IDLE, HDR, DATA, HOLD.
  - IDLE → HDR on synchronised `cs_n` fall. Clear the 5-bit bit counter.
  - HDR: shift 16 bits. On the 16th rise, latch the R/W flag and load `address`, then → DATA.
  - DATA: shift 8 bits.
    - Write: on the 8th rise, load `wdata` and assert `xfc` for 1 cycle.
    - Read: on the first `sck` fall in DATA, capture `rdata` into the output shift register and pulse `rd`. `miso` = bit 7 from that fall onward.
  - After a byte: → DATA (burst, see Configuration) or → HOLD.
  - HOLD: ignore `sck` until `cs_n` rises.
  - Any state → IDLE on synchronised `cs_n` rise.
- Abort: if `cs_n` rises mid-header or mid-byte:
  - partial bits are discarded;
  - no `xfc` or `rd` for that byte;
  - `address` and `wdata` keep their last values.
- `address` and `wdata` are stable in the cycle `xfc` is high.
- `miso` = 0 and `miso_oe` = 0 whenever `cs_n` is high.
- Reset values:
  - `address` = 0, `wdata` = 0.
  - `xfc` = 0, `rd` = 0.
  - `miso` = 0, `miso_oe` = 0.
  - state = IDLE, counters = 0.

## Timing
- Edge-to-action latency: a pad `sck` rise first sampled at clk edge E1 takes effect at E3 (shift, counter, `address`/`wdata` load). `xfc` is high during the cycle after E3.
- `rd` and the `rdata` capture occur at the clk edge E3 relative to the first DATA `sck` fall. `rdata` must be valid combinationally from `address` within 3 clk cycles of an `address` change.
- `xfc` and `rd` are always exactly 1 cycle wide. They never both assert in the same frame byte.
- `cs_n` fall to first `sck` rise: at least 4 clk cycles.

## Configuration
- Macro: `SPI_REG_BURST_EN`.
- Defined:
  - After each data byte, stay in DATA.
  - `address` increments by 1 in the clk cycle after that byte's `xfc` (write) or after its 8th `sck` rise (read).
  - Wraps 0x7FF → 0x000.
- Undefined:
  - After the first data byte, → HOLD.
  - Further bits are ignored and `address` never auto-increments.

## Structure
- Shared package `spi_reg_pkg`:
  - state enum (IDLE/HDR/DATA/HOLD);
  - `HDR_BITS` = 16, `BYTE_BITS` = 8;
  - R/W bit position and address field offsets.
- Sub-module `sync_edge`: 3-flop synchroniser with `rise`/`fall` outputs, instantiated for `sck` and `cs_n`. `mosi` uses its 2-flop synchroniser only.

## Test plan
- Reset mid-frame:
  - stimulus: assert `rst` after 10 header bits.
  - required: all outputs 0, state IDLE; a following clean frame works.
- Single write:
  - stimulus: frame 0x80_08_15 (write, addr 0x008, data 0x15).
  - required: one `xfc` pulse with `address` = 0x008 and `wdata` = 0x15 in that cycle, 3 clk after the last `sck` rise.
- Single read:
  - stimulus: header 0x00_08 with `rdata` = 0xA5.
  - required: one `rd` pulse; `miso` shifts 1,0,1,0,0,1,0,1; no `xfc`.
- Abort:
  - stimulus: raise `cs_n` after 5 data bits of a write.
  - required: no `xfc`; `address` and `wdata` unchanged from the previous frame.
- Burst write with `SPI_REG_BURST_EN`:
  - stimulus: addr 0x7FE, data 0x11, 0x22, 0x33.
  - required: 3 `xfc` pulses at `address` 0x7FE, 0x7FF, 0x000.
- Burst write without `SPI_REG_BURST_EN`:
  - stimulus: the same burst frame as above.
  - required: exactly 1 `xfc` (0x7FE, 0x11).

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and frame geometry for the SPI register-access front end.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int HDR_BITS   = 16;
  localparam int BYTE_BITS  = 8;
  localparam int FRAME_BITS = HDR_BITS + BYTE_BITS;
  // Positions within the 24-bit frame, MSB first on the wire.
  localparam int RW_BIT     = 23;
  localparam int ADDR_LSB   = 8;

endpackage

// File: rtl/spi_reg_slave_if.sv
// Pad-side SPI pins plus the register-file strobe bus of spi_reg_slave.
// Handshake: xfc and rd are single-cycle strobes with no backpressure; the register
// file must accept them in the cycle they are high, and address/wdata are valid then.
interface spi_reg_slave_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              xfc;
  logic              rd;
  logic [DATA_W-1:0] rdata;

  modport slave (
    input  sck, cs_n, mosi, rdata,
    output miso, miso_oe, address, wdata, xfc, rd
  );

  modport master (
    output sck, cs_n, mosi, rdata,
    input  miso, miso_oe, address, wdata, xfc, rd
  );
endinterface

// File: rtl/sync_edge.sv
// Three-flop synchroniser for an asynchronous pad input with rise/fall pulses.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {3{RST_VAL}};
    else      sync_q <= {sync_q[1:0], d};
  end

  // Stage 1 is the synchronised level; stage 2 is its one-cycle-old copy.
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-access slave: 16-bit header (R/W + address) then data bytes.
// Optional feature macro: SPI_REG_BURST_EN (stay in DATA and auto-increment address).
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  spi_reg_slave_if.slave     bus,
  output state_t             dbg_state
);
  localparam int SR_W = ADDR_W - 1;

  logic              sck_rise, sck_fall, cs_rise, cs_fall;
  logic [1:0]        mosi_sync;
  logic              mosi_s;
  state_t            state;
  logic [4:0]        bit_cnt;
  logic [SR_W-1:0]   in_sr;
  logic [DATA_W-2:0] out_sr;
  logic              rw_first, rw, load_pend, inc_pend;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              xfc, rd, miso, miso_oe;

  sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(bus.sck), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(bus.cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= 2'b00;
    else      mosi_sync <= {mosi_sync[0], bus.mosi};
  end
  assign mosi_s = mosi_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      rw_first  <= 1'b0;
      rw        <= 1'b0;
      load_pend <= 1'b0;
      inc_pend  <= 1'b0;
      address   <= '0;
      wdata     <= '0;
      xfc       <= 1'b0;
      rd        <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      xfc <= 1'b0;
      rd  <= 1'b0;
      // A completed byte's increment lands even if cs_n rises right after it.
      if (inc_pend) begin
        address  <= address + 1'b1;
        inc_pend <= 1'b0;
      end
      if (cs_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        load_pend <= 1'b0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= HDR;
              bit_cnt <= '0;
              miso    <= 1'b0;
              miso_oe <= 1'b1;
            end
          end
          HDR: begin
            if (sck_rise) begin
              in_sr <= {in_sr[SR_W-2:0], mosi_s};
              if (bit_cnt == 5'(FRAME_BITS - 1 - RW_BIT)) rw_first <= mosi_s;
              // The address field ends the header, so the last header bit completes it.
              if (bit_cnt == 5'(HDR_BITS - 1 - (ADDR_LSB - BYTE_BITS))) begin
                rw        <= rw_first;
                address   <= {in_sr, mosi_s};
                state     <= DATA;
                bit_cnt   <= '0;
                load_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (sck_rise) begin
              in_sr <= {in_sr[SR_W-2:0], mosi_s};
              if (bit_cnt == 5'(BYTE_BITS - 1)) begin
                if (rw) begin
                  wdata <= {in_sr[DATA_W-2:0], mosi_s};
                  xfc   <= 1'b1;
                end
                bit_cnt <= '0;
`ifdef SPI_REG_BURST_EN
                load_pend <= 1'b1;
                inc_pend  <= 1'b1;
`else
                state     <= HOLD;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sck_fall && !rw) begin
              if (load_pend) begin
                miso      <= bus.rdata[DATA_W-1];
                out_sr    <= bus.rdata[DATA_W-2:0];
                rd        <= 1'b1;
                load_pend <= 1'b0;
              end else begin
                miso   <= out_sr[DATA_W-2];
                out_sr <= {out_sr[DATA_W-3:0], 1'b0};
              end
            end
          end
          HOLD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.address = address;
  assign bus.wdata   = wdata;
  assign bus.xfc     = xfc;
  assign bus.rd      = rd;
  assign bus.miso    = miso;
  assign bus.miso_oe = miso_oe;
  assign dbg_state   = state;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed + randomized bench for spi_reg_slave against a frame-level reference model.
module tb_spi_reg_slave;
  import spi_reg_pkg::*;

`ifdef SPI_REG_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;
  always #5 clk = ~clk;

  spi_reg_slave_if #(.ADDR_W(11), .DATA_W(8)) bus ();

  spi_reg_slave #(.ADDR_W(11), .DATA_W(8)) dut (
    .clk(clk), .rst(rst_n), .bus(bus.slave), .dbg_state(dbg_state)
  );

  logic [7:0] mem [0:2047];
  assign bus.rdata = mem[bus.address];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations collected while a frame runs
  logic [18:0] xfc_obs_q[$];
  int          xfc_cyc_q[$];
  int          end_rise_q[$];
  logic [7:0]  miso_obs_q[$];
  int rd_cnt = 0, wide_cnt = 0, both_cnt = 0, cs_viol = 0, cs_high = 0, oe_bad = 0;
  logic xfc_d = 1'b0, rd_d = 1'b0;

  // Reference state: address/wdata the register file should currently see
  logic [18:0] exp_q[$];
  logic [10:0] m_addr;
  logic [7:0]  m_wdata;

  always @(negedge clk) begin
    cs_high = bus.cs_n ? cs_high + 1 : 0;
    if (rst_n) begin
      if (bus.xfc) begin
        xfc_obs_q.push_back({bus.address, bus.wdata});
        xfc_cyc_q.push_back(cyc);
      end
      if (bus.rd) rd_cnt++;
      if ((bus.xfc && xfc_d) || (bus.rd && rd_d)) wide_cnt++;
      if (bus.xfc && bus.rd) both_cnt++;
      if (cs_high > 4 && (bus.miso || bus.miso_oe)) cs_viol++;
      xfc_d = bus.xfc;
      rd_d  = bus.rd;
    end else begin
      xfc_d = 1'b0;
      rd_d  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Master side: sck half period of 6 clk, bits MSB first from {hdr, data}.
  task automatic do_frame(input logic [15:0] hdr, input logic [23:0] data,
                          input int nbits, input bit keep_cs);
    logic [39:0] f;
    logic [7:0]  acc;
    f = {hdr, data};
    acc = '0;
    xfc_obs_q.delete(); xfc_cyc_q.delete(); end_rise_q.delete(); miso_obs_q.delete();
    rd_cnt = 0;
    oe_bad = 0;
    wait_clk(2);
    bus.cs_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = f[39-i];
      wait_clk(6);
      if (!bus.miso_oe) oe_bad++;
      if (i >= 16) begin
        acc = {acc[6:0], bus.miso};
        if ((i - 16) % 8 == 7) miso_obs_q.push_back(acc);
      end
      bus.sck = 1'b1;
      if (i >= 16 && (i - 16) % 8 == 7) end_rise_q.push_back(cyc);
      wait_clk(6);
      bus.sck = 1'b0;
    end
    if (!keep_cs) begin
      wait_clk(6);
      bus.cs_n = 1'b1;
      wait_clk(8);
    end
  endtask

  // Frame-level model: which bytes complete, what the register file sees, what miso returns.
  task automatic check_frame(input string tag, input logic [15:0] hdr,
                             input logic [23:0] data, input int nbits);
    int          nb, n_rd;
    logic [10:0] a, ak;
    logic [7:0]  d;
    logic [7:0]  exp_miso_q[$];
    exp_q.delete();
    nb   = (nbits >= 16) ? (nbits - 16) / 8 : 0;
    if (!BURST && nb > 1) nb = 1;
    n_rd = 0;
    if (nbits >= 16) begin
      a = hdr[10:0];
      for (int k = 0; k < nb; k++) begin
        d  = data[23-8*k -: 8];
        ak = a + 11'(k);
        if (hdr[15]) begin
          exp_q.push_back({ak, d});
          m_wdata = d;
        end else begin
          exp_miso_q.push_back(mem[ak]);
        end
      end
      // Every DATA-state sck fall that starts a byte fetches rdata (prefetch in burst).
      if (!hdr[15]) n_rd = BURST ? (nbits - 16) / 8 + 1 : 1;
      m_addr = BURST ? a + 11'(nb) : a;
    end
    chk($sformatf("%s xfc_count", tag), xfc_obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < xfc_obs_q.size(); k++) begin
      chk($sformatf("%s xfc[%0d] addr/data", tag, k), 32'(xfc_obs_q[k]), 32'(exp_q[k]));
      if (k < end_rise_q.size())
        chk($sformatf("%s xfc[%0d] latency", tag, k), xfc_cyc_q[k] - end_rise_q[k], 3);
    end
    chk($sformatf("%s rd_count", tag), rd_cnt, n_rd);
    for (int k = 0; k < exp_miso_q.size(); k++) begin
      if (k < miso_obs_q.size())
        chk($sformatf("%s miso_byte[%0d]", tag, k), 32'(miso_obs_q[k]), 32'(exp_miso_q[k]));
      else
        chk($sformatf("%s miso_byte[%0d] missing", tag, k), 32'(miso_obs_q.size()), 32'(k + 1));
    end
    chk($sformatf("%s address", tag), 32'(bus.address), 32'(m_addr));
    chk($sformatf("%s wdata", tag), 32'(bus.wdata), 32'(m_wdata));
    chk($sformatf("%s miso_oe_in_frame", tag), oe_bad, 0);
    chk($sformatf("%s state_idle", tag), 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " address"}, 32'(bus.address), 32'h0);
    chk({tag, " wdata"},   32'(bus.wdata),   32'h0);
    chk({tag, " xfc"},     32'(bus.xfc),     32'h0);
    chk({tag, " rd"},      32'(bus.rd),      32'h0);
    chk({tag, " miso"},    32'(bus.miso),    32'h0);
    chk({tag, " miso_oe"}, 32'(bus.miso_oe), 32'h0);
    chk({tag, " state"},   32'(dbg_state),   32'(IDLE));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nbits_tab[6];
    logic [15:0] hdr;
    logic [23:0] data;
    int          nbits;

    nbits_tab = '{24, 40, 16, 21, 32, 29};
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[11'h008] = 8'hA5;

    // Clock/reset
    rst_n = 1'b0;
    bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    m_addr = '0; m_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    chk_reset_outputs("post_por");

    // Reset in the middle of a header
    do_frame(16'h8123, 24'h5A0000, 10, 1'b1);
    rst_n = 1'b0;
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    #1;
    chk_reset_outputs("mid_hdr_reset");
    wait_clk(3);
    rst_n = 1'b1;
    m_addr = '0; m_wdata = '0;
    wait_clk(6);

    // Single write, single read, abort with the same address
    do_frame(16'h8008, 24'h150000, 24, 1'b0);
    check_frame("write", 16'h8008, 24'h150000, 24);
    do_frame(16'h0008, 24'h000000, 24, 1'b0);
    check_frame("read", 16'h0008, 24'h000000, 24);
    do_frame(16'h8008, 24'hC30000, 21, 1'b0);
    check_frame("abort", 16'h8008, 24'hC30000, 21);

    // Burst across the address wrap
    do_frame(16'h87FE, 24'h112233, 40, 1'b0);
    check_frame("burst_wrap", 16'h87FE, 24'h112233, 40);

    // Randomized frames, reserved bits randomized too
    for (int n = 0; n < 8; n++) begin
      hdr   = 16'($urandom);
      data  = 24'($urandom);
      nbits = nbits_tab[$urandom_range(0, 5)];
      do_frame(hdr, data, nbits, 1'b0);
      check_frame($sformatf("rand%0d", n), hdr, data, nbits);
    end

    chk("strobe_width", wide_cnt, 0);
    chk("xfc_rd_overlap", both_cnt, 0);
    chk("cs_high_outputs", cs_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
